// File: rtl/mem_port_ctrl_pkg.sv
// Shared types and constants for the memory-port sequencer/arbiter.
package mem_port_ctrl_pkg;

  localparam int WORD_SIZE = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_D  = 1'b1
  } src_t;

endpackage

// File: rtl/mem_port_ctrl_if.sv
// Requester-side handshake bundle: instruction fetch (if_*) and load/store (d_*).
interface mem_port_ctrl_if #(
  parameter int WORD_SIZE = 16
);
  logic                 if_req;
  logic [WORD_SIZE-1:0] if_addr;
  logic                 if_grant;
  logic                 if_valid;
  logic [WORD_SIZE-1:0] if_rdata;

  logic                 d_req;
  logic                 d_we;
  logic [WORD_SIZE-1:0] d_addr;
  logic [WORD_SIZE-1:0] d_wdata;
  logic                 d_grant;
  logic                 d_done;
  logic [WORD_SIZE-1:0] d_rdata;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
    input  if_grant, if_valid, if_rdata, d_grant, d_done, d_rdata
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
    output if_grant, if_valid, if_rdata, d_grant, d_done, d_rdata
  );
endinterface

// File: rtl/mem_port_ctrl_lat_counter.sv
// 4-bit loadable down-counter timing how long the memory strobe is held.
module mem_lat_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/mem_port_ctrl.sv
// Arbitrates IF and D requesters onto one memory port and holds the strobes
// for MEM_LATENCY cycles.
//   state  | meaning
//   IDLE   | bus released, arbitration open (D beats IF)
//   ACCESS | strobe held on latched address, latency counter running
//   RESP   | strobes dropped, valid/done pulse to the winning source
module mem_port_ctrl
  import mem_port_ctrl_pkg::*;
#(
  parameter int WORD_SIZE   = mem_port_ctrl_pkg::WORD_SIZE,
  parameter int MEM_LATENCY = 2
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  mem_port_ctrl_if.slave       rq,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 busy
);

  state_t               state;
  src_t                 src_q;
  logic                 we_q;
  logic [WORD_SIZE-1:0] wdata_q;
  logic                 grant_d;
  logic                 grant_if;
  logic                 cnt_zero;

  // Grants are gated by reset so nothing is accepted while the port is held.
  assign grant_d  = Reset_N && (state == IDLE) && rq.d_req;
  assign grant_if = Reset_N && (state == IDLE) && rq.if_req && !rq.d_req;

  assign rq.d_grant  = grant_d;
  assign rq.if_grant = grant_if;
  assign busy        = (state != IDLE);
  assign data        = writeM ? wdata_q : {WORD_SIZE{1'bz}};

  mem_lat_counter u_lat_counter (
    .clk      (Clk),
    .rst_n    (Reset_N),
    .load     (grant_d || grant_if),
    .dec      (state == ACCESS),
    .load_val (4'(MEM_LATENCY - 1)),
    .zero     (cnt_zero)
  );

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state       <= IDLE;
      src_q       <= SRC_IF;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      readM       <= 1'b0;
      writeM      <= 1'b0;
      address     <= '0;
      rq.if_valid <= 1'b0;
      rq.d_done   <= 1'b0;
      rq.if_rdata <= '0;
      rq.d_rdata  <= '0;
    end else begin
      rq.if_valid <= 1'b0;
      rq.d_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d || grant_if) begin
            state   <= ACCESS;
            src_q   <= grant_d ? SRC_D : SRC_IF;
            we_q    <= grant_d && rq.d_we;
            wdata_q <= rq.d_wdata;
            address <= grant_d ? rq.d_addr : rq.if_addr;
            readM   <= !(grant_d && rq.d_we);
            writeM  <= grant_d && rq.d_we;
          end
        end
        ACCESS: begin
          if (cnt_zero) begin
            state       <= RESP;
            readM       <= 1'b0;
            writeM      <= 1'b0;
            // valid/done are registered here so they are high for the RESP cycle
            rq.if_valid <= (src_q == SRC_IF);
            rq.d_done   <= (src_q == SRC_D);
            if (!we_q) begin
              if (src_q == SRC_D) rq.d_rdata  <= data;
              else                rq.if_rdata <= data;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed self-checking bench: one DUT at MEM_LATENCY=2, one at MEM_LATENCY=1.
module tb_mem_port_ctrl;

  logic Clk;
  logic Reset_N;

  mem_port_ctrl_if #(.WORD_SIZE(16)) rq_a ();
  mem_port_ctrl_if #(.WORD_SIZE(16)) rq_b ();

  logic        readM_a, writeM_a, busy_a;
  logic [15:0] address_a;
  wire  [15:0] data_a;
  logic        readM_b, writeM_b, busy_b;
  logic [15:0] address_b;
  wire  [15:0] data_b;

  int checks;
  int failures;

  // Memory model: word = address ^ 16'h6A11; drives 0 on an idle bus, releases on store.
  assign data_a = writeM_a ? 16'hzzzz : (readM_a ? (address_a ^ 16'h6A11) : 16'h0000);
  assign data_b = writeM_b ? 16'hzzzz : (readM_b ? (address_b ^ 16'h6A11) : 16'h0000);

  mem_port_ctrl #(.WORD_SIZE(16), .MEM_LATENCY(2)) dut_a (
    .Clk     (Clk),
    .Reset_N (Reset_N),
    .rq      (rq_a),
    .readM   (readM_a),
    .writeM  (writeM_a),
    .address (address_a),
    .data    (data_a),
    .busy    (busy_a)
  );

  mem_port_ctrl #(.WORD_SIZE(16), .MEM_LATENCY(1)) dut_b (
    .Clk     (Clk),
    .Reset_N (Reset_N),
    .rq      (rq_b),
    .readM   (readM_b),
    .writeM  (writeM_b),
    .address (address_b),
    .data    (data_b),
    .busy    (busy_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic test_reset();
    Reset_N = 1'b0;
    rq_a.if_req = 1'b1;
    rq_a.if_addr = 16'h0000;
    repeat (3) @(negedge Clk);
    checks++;
    if (rq_a.if_grant !== 1'b0) begin
      failures++; $display("FAIL reset_no_grant: got %b exp 0", rq_a.if_grant);
    end
    checks++;
    if ({readM_a, writeM_a, busy_a, rq_a.if_valid, rq_a.d_done} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl: got %b exp 00000",
        {readM_a, writeM_a, busy_a, rq_a.if_valid, rq_a.d_done});
    end
    checks++;
    if ({address_a, rq_a.if_rdata, rq_a.d_rdata} !== 48'h0) begin
      failures++; $display("FAIL reset_regs: got %h exp 0", {address_a, rq_a.if_rdata, rq_a.d_rdata});
    end
    checks++;
    if (data_a !== 16'h0000) begin
      failures++; $display("FAIL reset_bus_released: got %h exp 0000", data_a);
    end
    Reset_N = 1'b1;
    #1;
    checks++;
    if (rq_a.if_grant !== 1'b1) begin
      failures++; $display("FAIL reset_release_grant: got %b exp 1", rq_a.if_grant);
    end
    rq_a.if_req = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_fetch();
    @(negedge Clk);
    rq_a.if_req = 1'b1;
    rq_a.if_addr = 16'h0010;
    #1;
    checks++;
    if (rq_a.if_grant !== 1'b1) begin
      failures++; $display("FAIL fetch_grant: got %b exp 1", rq_a.if_grant);
    end
    @(posedge Clk); #1;
    rq_a.if_req = 1'b0;
    rq_a.if_addr = 16'hFFFF;
    for (int k = 1; k <= 4; k++) begin
      @(negedge Clk);
      checks++;
      if (readM_a !== (k <= 2)) begin
        failures++; $display("FAIL fetch_readM_c%0d: got %b exp %b", k, readM_a, (k <= 2));
      end
      checks++;
      if (rq_a.if_valid !== (k == 3)) begin
        failures++; $display("FAIL fetch_valid_c%0d: got %b exp %b", k, rq_a.if_valid, (k == 3));
      end
      if (k <= 2) begin
        checks++;
        if (address_a !== 16'h0010) begin
          failures++; $display("FAIL fetch_addr_c%0d: got %h exp 0010", k, address_a);
        end
      end
    end
    checks++;
    if (rq_a.if_rdata !== 16'h6A01) begin
      failures++; $display("FAIL fetch_rdata: got %h exp 6A01", rq_a.if_rdata);
    end
    checks++;
    if (busy_a !== 1'b0) begin
      failures++; $display("FAIL fetch_idle_again: got busy %b exp 0", busy_a);
    end
  endtask

  task automatic test_contention();
    int done_k, grant_k, valid_k;
    done_k = 0; grant_k = 0; valid_k = 0;
    @(negedge Clk);
    rq_a.d_req = 1'b1; rq_a.d_we = 1'b0; rq_a.d_addr = 16'h0100;
    rq_a.if_req = 1'b1; rq_a.if_addr = 16'h0200;
    #1;
    checks++;
    if ({rq_a.d_grant, rq_a.if_grant} !== 2'b10) begin
      failures++; $display("FAIL cont_first_grant: got d/if %b exp 10", {rq_a.d_grant, rq_a.if_grant});
    end
    @(posedge Clk); #1;
    rq_a.d_req = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge Clk);
      if (rq_a.d_done && done_k == 0) done_k = k;
      if (rq_a.if_valid && valid_k == 0) valid_k = k;
      if (rq_a.if_grant && grant_k == 0) grant_k = k;
      @(posedge Clk); #1;
      if (grant_k != 0) rq_a.if_req = 1'b0;
    end
    checks++;
    if (done_k != 3) begin
      failures++; $display("FAIL cont_d_done_cycle: got %0d exp 3", done_k);
    end
    checks++;
    if (grant_k != 4) begin
      failures++; $display("FAIL cont_if_grant_cycle: got %0d exp 4", grant_k);
    end
    checks++;
    if (valid_k != 7) begin
      failures++; $display("FAIL cont_if_valid_cycle: got %0d exp 7", valid_k);
    end
    checks++;
    if (rq_a.d_rdata !== 16'h6B11) begin
      failures++; $display("FAIL cont_d_rdata: got %h exp 6B11", rq_a.d_rdata);
    end
    checks++;
    if (rq_a.if_rdata !== 16'h6811) begin
      failures++; $display("FAIL cont_if_rdata: got %h exp 6811", rq_a.if_rdata);
    end
  endtask

  task automatic test_store();
    @(negedge Clk);
    rq_a.d_req = 1'b1; rq_a.d_we = 1'b1;
    rq_a.d_addr = 16'h0042; rq_a.d_wdata = 16'hBEEF;
    #1;
    checks++;
    if (rq_a.d_grant !== 1'b1) begin
      failures++; $display("FAIL store_grant: got %b exp 1", rq_a.d_grant);
    end
    @(posedge Clk); #1;
    rq_a.d_req = 1'b0;
    rq_a.d_wdata = 16'h0000;
    rq_a.d_addr = 16'h1234;
    for (int k = 1; k <= 4; k++) begin
      @(negedge Clk);
      checks++;
      if ({writeM_a, readM_a} !== {(k <= 2), 1'b0}) begin
        failures++; $display("FAIL store_strobes_c%0d: got w/r %b exp %b0", k, {writeM_a, readM_a}, (k <= 2));
      end
      checks++;
      if (data_a !== ((k <= 2) ? 16'hBEEF : 16'h0000)) begin
        failures++; $display("FAIL store_data_c%0d: got %h exp %h", k, data_a, ((k <= 2) ? 16'hBEEF : 16'h0000));
      end
      checks++;
      if (rq_a.d_done !== (k == 3)) begin
        failures++; $display("FAIL store_done_c%0d: got %b exp %b", k, rq_a.d_done, (k == 3));
      end
      if (k <= 2) begin
        checks++;
        if (address_a !== 16'h0042) begin
          failures++; $display("FAIL store_addr_c%0d: got %h exp 0042", k, address_a);
        end
      end
    end
    checks++;
    if (rq_a.d_rdata !== 16'h6B11) begin
      failures++; $display("FAIL store_rdata_kept: got %h exp 6B11", rq_a.d_rdata);
    end
    rq_a.d_we = 1'b0;
  endtask

  task automatic test_mid_reset();
    @(negedge Clk);
    rq_a.d_req = 1'b1; rq_a.d_we = 1'b0; rq_a.d_addr = 16'h0300;
    @(posedge Clk); #1;
    rq_a.d_req = 1'b0;
    @(negedge Clk);
    checks++;
    if (readM_a !== 1'b1) begin
      failures++; $display("FAIL midrst_access: got readM %b exp 1", readM_a);
    end
    Reset_N = 1'b0;
    #1;
    checks++;
    if ({readM_a, writeM_a, busy_a} !== 3'b000) begin
      failures++; $display("FAIL midrst_strobes: got r/w/busy %b exp 000", {readM_a, writeM_a, busy_a});
    end
    checks++;
    if ({address_a, rq_a.d_rdata, rq_a.if_rdata} !== 48'h0) begin
      failures++; $display("FAIL midrst_regs: got %h exp 0", {address_a, rq_a.d_rdata, rq_a.if_rdata});
    end
    repeat (2) @(negedge Clk);
    Reset_N = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge Clk);
      checks++;
      if ({rq_a.d_done, busy_a} !== 2'b00) begin
        failures++; $display("FAIL midrst_quiet_c%0d: got done/busy %b exp 00", k, {rq_a.d_done, busy_a});
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_grant, n_valid;
    int valid_k [3];
    logic [15:0] exp_rd [3];
    n_grant = 0; n_valid = 0;
    for (int i = 0; i < 3; i++) valid_k[i] = 0;
    exp_rd[0] = 16'h6A11; exp_rd[1] = 16'h6A10; exp_rd[2] = 16'h6A13;
    @(negedge Clk);
    rq_b.if_req = 1'b1; rq_b.if_addr = 16'h0000;
    #1;
    checks++;
    if (rq_b.if_grant !== 1'b1) begin
      failures++; $display("FAIL b2b_first_grant: got %b exp 1", rq_b.if_grant);
    end
    @(posedge Clk); #1;
    n_grant = 1;
    rq_b.if_addr = 16'h0001;
    for (int k = 1; k <= 12; k++) begin
      logic granted;
      @(negedge Clk);
      granted = rq_b.if_grant;
      if (rq_b.if_valid) begin
        if (n_valid < 3) begin
          valid_k[n_valid] = k;
          checks++;
          if (rq_b.if_rdata !== exp_rd[n_valid]) begin
            failures++; $display("FAIL b2b_rdata_%0d: got %h exp %h", n_valid, rq_b.if_rdata, exp_rd[n_valid]);
          end
        end
        n_valid++;
      end
      @(posedge Clk); #1;
      if (granted) begin
        n_grant++;
        rq_b.if_addr = 16'(n_grant);
        if (n_grant == 3) rq_b.if_req = 1'b0;
      end
    end
    checks++;
    if (n_valid != 3) begin
      failures++; $display("FAIL b2b_count: got %0d exp 3", n_valid);
    end
    checks++;
    if (valid_k[0] != 2 || valid_k[1] != 5 || valid_k[2] != 8) begin
      failures++; $display("FAIL b2b_valid_cycles: got %0d,%0d,%0d exp 2,5,8", valid_k[0], valid_k[1], valid_k[2]);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    Reset_N = 1'b0;
    rq_a.if_req = 1'b0; rq_a.if_addr = '0;
    rq_a.d_req = 1'b0; rq_a.d_we = 1'b0; rq_a.d_addr = '0; rq_a.d_wdata = '0;
    rq_b.if_req = 1'b0; rq_b.if_addr = '0;
    rq_b.d_req = 1'b0; rq_b.d_we = 1'b0; rq_b.d_addr = '0; rq_b.d_wdata = '0;

    test_reset();
    test_fetch();
    test_contention();
    test_store();
    test_mid_reset();
    test_back_to_back();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
